i2c_slave_byte_ctrl: RTL

I2C slave byte engine, the target-side counterpart of the master byte controller. It oversamples SCL/SDA on the system clock and detects START, repeated START and STOP. It matches a 7-bit address, ACKs, then shifts bytes in (master write) or out (master read). It sits between the bus pads (open-drain `*_o`/`*_oen` pairs) and a user register/FIFO interface with per-byte handshakes.

---
 rtl/i2c_slave_byte_ctrl.sv | 351 +++++++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/i2c_slave_byte_ctrl.sv
// I2C target-side byte engine: oversampled START/STOP detection, 7-bit address match, byte RX/TX.
// Optional SCL stretching on TX data starvation is enabled by defining I2C_SLAVE_CLK_STRETCH_EN.
module i2c_slave_byte_ctrl #(
  parameter int unsigned SETUP_CYC = 4
) (
  input  logic       clk,
  input  logic       nReset,
  input  logic       ena,
  input  logic [6:0] slave_addr,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       scl_o,
  output logic       scl_oen,
  output logic       sda_o,
  output logic       sda_oen,
  output logic       busy,
  output logic       addressed,
  output logic       rw,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_nack,
  output logic       tx_req,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_underrun,
  output logic [2:0] dbg_state
);

`ifdef I2C_SLAVE_CLK_STRETCH_EN
  localparam bit STRETCH_EN = 1'b1;
`else
  localparam bit STRETCH_EN = 1'b0;
`endif

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ADDR     = 3'd1,
    ST_ADDR_ACK = 3'd2,
    ST_RX       = 3'd3,
    ST_RX_ACK   = 3'd4,
    ST_TX       = 3'd5,
    ST_TX_ACK   = 3'd6
  } state_t;

  state_t      state_q, state_d;
  logic        scl_s1_q, scl_s1_d, scl_s2_q, scl_s2_d, scl_h_q, scl_h_d;
  logic        sda_s1_q, sda_s1_d, sda_s2_q, sda_s2_d, sda_h_q, sda_h_d;
  logic        scl_rise_q, scl_rise_d, scl_fall_q, scl_fall_d;
  logic        start_q, start_d, stop_q, stop_d, sda_smp_q, sda_smp_d;
  logic [2:0]  bitcnt_q, bitcnt_d;
  logic [7:0]  sr_q, sr_d;
  logic        phase_q, phase_d;
  logic        nack_q, nack_d;
  logic        sda_oen_q, sda_oen_d, scl_oen_q, scl_oen_d;
  logic        busy_q, busy_d, addressed_q, addressed_d, rw_q, rw_d;
  logic [7:0]  rx_data_q, rx_data_d;
  logic        rx_valid_q, rx_valid_d;
  logic        tx_req_q, tx_req_d;
  logic [7:0]  hold_q, hold_d;
  logic        fresh_q, fresh_d;
  logic        tx_underrun_q, tx_underrun_d;
  logic        stretch_wait_q, stretch_wait_d, stretch_setup_q, stretch_setup_d;
  logic [7:0]  setup_cnt_q, setup_cnt_d;
  logic        byte_start;

  always_comb begin
    state_d         = state_q;
    scl_s1_d        = scl_i;
    scl_s2_d        = scl_s1_q;
    scl_h_d         = scl_s2_q;
    sda_s1_d        = sda_i;
    sda_s2_d        = sda_s1_q;
    sda_h_d         = sda_s2_q;
    // Edge and bus-condition pulses are registered so every FSM action sees the same sample.
    scl_rise_d      = scl_s2_q & ~scl_h_q;
    scl_fall_d      = ~scl_s2_q & scl_h_q;
    start_d         = scl_s2_q & scl_h_q & sda_h_q & ~sda_s2_q;
    stop_d          = scl_s2_q & scl_h_q & ~sda_h_q & sda_s2_q;
    sda_smp_d       = sda_s2_q;
    bitcnt_d        = bitcnt_q;
    sr_d            = sr_q;
    phase_d         = phase_q;
    nack_d          = rx_valid_q ? rx_nack : nack_q;
    sda_oen_d       = sda_oen_q;
    scl_oen_d       = scl_oen_q;
    busy_d          = busy_q;
    addressed_d     = addressed_q;
    rw_d            = rw_q;
    rx_data_d       = rx_data_q;
    rx_valid_d      = 1'b0;
    tx_req_d        = tx_req_q;
    hold_d          = hold_q;
    fresh_d         = fresh_q;
    tx_underrun_d   = 1'b0;
    stretch_wait_d  = stretch_wait_q;
    stretch_setup_d = stretch_setup_q;
    setup_cnt_d     = setup_cnt_q;
    byte_start      = 1'b0;

    if (tx_valid && tx_req_q) begin
      hold_d   = tx_data;
      fresh_d  = 1'b1;
      tx_req_d = 1'b0;
    end

    if (!ena) begin
      state_d         = ST_IDLE;
      sda_oen_d       = 1'b1;
      scl_oen_d       = 1'b1;
      busy_d          = 1'b0;
      addressed_d     = 1'b0;
      tx_req_d        = 1'b0;
      stretch_wait_d  = 1'b0;
      stretch_setup_d = 1'b0;
    end else if (start_q) begin
      state_d         = ST_ADDR;
      bitcnt_d        = 3'd7;
      sda_oen_d       = 1'b1;
      scl_oen_d       = 1'b1;
      busy_d          = 1'b1;
      addressed_d     = 1'b0;
      tx_req_d        = 1'b0;
      stretch_wait_d  = 1'b0;
      stretch_setup_d = 1'b0;
    end else if (stop_q) begin
      state_d         = ST_IDLE;
      sda_oen_d       = 1'b1;
      scl_oen_d       = 1'b1;
      busy_d          = 1'b0;
      addressed_d     = 1'b0;
      tx_req_d        = 1'b0;
      stretch_wait_d  = 1'b0;
      stretch_setup_d = 1'b0;
    end else begin
      if (stretch_setup_q) begin
        if (setup_cnt_q <= 8'd1) begin
          scl_oen_d       = 1'b1;
          stretch_setup_d = 1'b0;
        end else begin
          setup_cnt_d = setup_cnt_q - 8'd1;
        end
      end

      case (state_q)
        ST_IDLE: ;
        ST_ADDR: begin
          if (scl_rise_q) begin
            sr_d = {sr_q[6:0], sda_smp_q};
            if (bitcnt_q == 3'd0) begin
              if (sr_q[6:0] == slave_addr) begin
                rw_d    = sda_smp_q;
                phase_d = 1'b0;
                state_d = ST_ADDR_ACK;
              end else begin
                state_d = ST_IDLE;
              end
            end else begin
              bitcnt_d = bitcnt_q - 3'd1;
            end
          end
        end
        ST_ADDR_ACK: begin
          if (scl_fall_q) begin
            if (!phase_q) begin
              sda_oen_d   = 1'b0;
              addressed_d = 1'b1;
              phase_d     = 1'b1;
              if (rw_q) tx_req_d = 1'b1;
            end else if (rw_q) begin
              byte_start = 1'b1;
            end else begin
              sda_oen_d = 1'b1;
              bitcnt_d  = 3'd7;
              state_d   = ST_RX;
            end
          end
        end
        ST_RX: begin
          if (scl_rise_q) begin
            sr_d = {sr_q[6:0], sda_smp_q};
            if (bitcnt_q == 3'd0) begin
              rx_data_d  = {sr_q[6:0], sda_smp_q};
              rx_valid_d = 1'b1;
              phase_d    = 1'b0;
              state_d    = ST_RX_ACK;
            end else begin
              bitcnt_d = bitcnt_q - 3'd1;
            end
          end
        end
        ST_RX_ACK: begin
          if (scl_fall_q) begin
            if (!phase_q) begin
              sda_oen_d = nack_q;
              phase_d   = 1'b1;
            end else begin
              sda_oen_d = 1'b1;
              if (nack_q) begin
                addressed_d = 1'b0;
                state_d     = ST_IDLE;
              end else begin
                bitcnt_d = 3'd7;
                state_d  = ST_RX;
              end
            end
          end
        end
        ST_TX: begin
          if (stretch_wait_q) begin
            // SCL is held low here, so no bus edges arrive until the data shows up.
            if (fresh_q) begin
              sr_d            = hold_q;
              sda_oen_d       = hold_q[7];
              fresh_d         = 1'b0;
              bitcnt_d        = 3'd7;
              stretch_wait_d  = 1'b0;
              stretch_setup_d = 1'b1;
              setup_cnt_d     = 8'(SETUP_CYC);
            end
          end else if (scl_fall_q) begin
            if (bitcnt_q == 3'd0) begin
              sda_oen_d = 1'b1;
              phase_d   = 1'b0;
              state_d   = ST_TX_ACK;
            end else begin
              sr_d      = sr_q << 1;
              sda_oen_d = sr_d[7];
              bitcnt_d  = bitcnt_q - 3'd1;
            end
          end
        end
        ST_TX_ACK: begin
          if (scl_rise_q && !phase_q) begin
            if (!sda_smp_q) begin
              phase_d  = 1'b1;
              tx_req_d = 1'b1;
            end else begin
              addressed_d = 1'b0;
              tx_req_d    = 1'b0;
              state_d     = ST_IDLE;
            end
          end else if (scl_fall_q && phase_q) begin
            byte_start = 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase

      if (byte_start) begin
        state_d  = ST_TX;
        bitcnt_d = 3'd7;
        if (fresh_q) begin
          sr_d      = hold_q;
          sda_oen_d = hold_q[7];
          fresh_d   = 1'b0;
        end else if (STRETCH_EN) begin
          sda_oen_d      = 1'b1;
          scl_oen_d      = 1'b0;
          stretch_wait_d = 1'b1;
          tx_req_d       = 1'b1;
        end else begin
          // Starved: resend whatever the holding register last held.
          sr_d          = hold_q;
          sda_oen_d     = hold_q[7];
          tx_underrun_d = 1'b1;
          tx_req_d      = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      state_q         <= ST_IDLE;
      scl_s1_q        <= 1'b1;
      scl_s2_q        <= 1'b1;
      scl_h_q         <= 1'b1;
      sda_s1_q        <= 1'b1;
      sda_s2_q        <= 1'b1;
      sda_h_q         <= 1'b1;
      scl_rise_q      <= 1'b0;
      scl_fall_q      <= 1'b0;
      start_q         <= 1'b0;
      stop_q          <= 1'b0;
      sda_smp_q       <= 1'b1;
      bitcnt_q        <= 3'd7;
      sr_q            <= 8'h00;
      phase_q         <= 1'b0;
      nack_q          <= 1'b0;
      sda_oen_q       <= 1'b1;
      scl_oen_q       <= 1'b1;
      busy_q          <= 1'b0;
      addressed_q     <= 1'b0;
      rw_q            <= 1'b0;
      rx_data_q       <= 8'h00;
      rx_valid_q      <= 1'b0;
      tx_req_q        <= 1'b0;
      hold_q          <= 8'hFF;
      fresh_q         <= 1'b0;
      tx_underrun_q   <= 1'b0;
      stretch_wait_q  <= 1'b0;
      stretch_setup_q <= 1'b0;
      setup_cnt_q     <= 8'h00;
    end else begin
      state_q         <= state_d;
      scl_s1_q        <= scl_s1_d;
      scl_s2_q        <= scl_s2_d;
      scl_h_q         <= scl_h_d;
      sda_s1_q        <= sda_s1_d;
      sda_s2_q        <= sda_s2_d;
      sda_h_q         <= sda_h_d;
      scl_rise_q      <= scl_rise_d;
      scl_fall_q      <= scl_fall_d;
      start_q         <= start_d;
      stop_q          <= stop_d;
      sda_smp_q       <= sda_smp_d;
      bitcnt_q        <= bitcnt_d;
      sr_q            <= sr_d;
      phase_q         <= phase_d;
      nack_q          <= nack_d;
      sda_oen_q       <= sda_oen_d;
      scl_oen_q       <= scl_oen_d;
      busy_q          <= busy_d;
      addressed_q     <= addressed_d;
      rw_q            <= rw_d;
      rx_data_q       <= rx_data_d;
      rx_valid_q      <= rx_valid_d;
      tx_req_q        <= tx_req_d;
      hold_q          <= hold_d;
      fresh_q         <= fresh_d;
      tx_underrun_q   <= tx_underrun_d;
      stretch_wait_q  <= stretch_wait_d;
      stretch_setup_q <= stretch_setup_d;
      setup_cnt_q     <= setup_cnt_d;
    end
  end

  assign scl_o       = 1'b0;
  assign sda_o       = 1'b0;
  assign scl_oen     = scl_oen_q;
  assign sda_oen     = sda_oen_q;
  assign busy        = busy_q;
  assign addressed   = addressed_q;
  assign rw          = rw_q;
  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign tx_req      = tx_req_q;
  assign tx_underrun = tx_underrun_q;
  assign dbg_state   = state_q;

endmodule
